// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package adder_seq_pkg;

    // Width of one adder slice; the shared cell is a 4-bit adder.
    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/Adder4bit.sv
// Combinational 4-bit adder cell with carry-in and carry-out.
module Adder4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = 5'(A) + 5'(B) + 5'(Cin);

endmodule

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial W-bit add/subtract: iterates one Adder4bit cell LSB slice first,
// with valid/ready handshakes on the operand and result sides.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int unsigned NSLICE = W / SLICE_W;
    localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((W % SLICE_W) != 0 || W < SLICE_W) begin : g_bad_width
        $error("adder_seq_ctrl: W must be a non-zero multiple of 4");
    end

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [31:0]        slice_base;
    logic [SLICE_W-1:0] cell_a, cell_b, cell_sum;
    logic               cell_cout;
    logic               last_slice;

    assign slice_base = 32'(idx_q) * SLICE_W;
    assign cell_a     = a_q[slice_base +: SLICE_W];
    assign cell_b     = b_q[slice_base +: SLICE_W];
    assign last_slice = (idx_q == IdxW'(NSLICE - 1));

    Adder4bit u_cell (
        .A    (cell_a),
        .B    (cell_b),
        .Cin  (carry_q),
        .Sum  (cell_sum),
        .Cout (cell_cout)
    );

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    // Next-state: operand capture, slice iteration and result hold.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction becomes A + ~B + ~borrow, so the mode needs no
                    // storage beyond the pre-inverted B and carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ^ cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[slice_base +: SLICE_W] = cell_sum;
                carry_d = cell_cout;
                if (last_slice) begin
                    idx_d   = '0;
                    cout_d  = cell_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (cell_sum[SLICE_W-1] != a_q[W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (W=16): directed table, corner
// sequences and random operations against an integer-arithmetic model.
module tb_adder_seq_ctrl;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    adder_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                         input logic msub, output logic [W-1:0] msum, output logic mcout,
                         output logic movf);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            ur    = ua + ub + int'(mcin);
            sr    = sa + sb + int'(mcin);
            mcout = (ur > 65535);
        end else begin
            ur    = ua - ub - int'(mcin);
            sr    = sa - sb - int'(mcin);
            mcout = (ur >= 0);
        end
        msum = ur[W-1:0];
        movf = (sr > 32767) || (sr < -32768);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles of out_ready=0 once the result shows.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                          input logic osub, input int hold, input string name,
                          output logic [W-1:0] rsum, output logic rcout, output logic rovf);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = oa; b = ob; cin = ocin; sub = osub;
        out_ready = 1'b0;
        step();
        // Scramble operands: accepted values must already be captured.
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(NSLICE));
        for (int i = 0; i < hold; i++) step();
        rsum = sum; rcout = cout; rovf = overflow;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    endtask

    vec_t         vecs[6];
    logic [W-1:0] gs, es, held_sum;
    logic         gc, go, ec, eo, held_c, held_o;
    logic         saw_valid;

    initial begin
        vecs[0] = '{"add b+4",      16'h000B, 16'h0004, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0};
        vecs[1] = '{"add ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"add ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"sub borrowin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'h0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, vecs[i].name, gs, gc, go);
            check({vecs[i].name, " sum"}, 32'(gs), 32'(vecs[i].exp_sum));
            check({vecs[i].name, " cout"}, 32'(gc), 32'(vecs[i].exp_cout));
            check({vecs[i].name, " overflow"}, 32'(go), 32'(vecs[i].exp_ovf));
        end

        // Backpressure: result held 10 cycles while the requester pokes the inputs.
        in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("bp out_valid", 32'(out_valid), 32'd1);
        held_sum = sum; held_c = cout; held_o = overflow;
        check("bp sum", 32'(held_sum), 32'h5555);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            step();
            check("bp sum stable", 32'(sum), 32'(held_sum));
            check("bp cout stable", 32'(cout), 32'(held_c));
            check("bp ovf stable", 32'(overflow), 32'(held_o));
            check("bp in_ready low", 32'(in_ready), 32'd0);
            check("bp out_valid high", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp back to idle", 32'(in_ready), 32'd1);
        check("bp out_valid dropped", 32'(out_valid), 32'd0);
        step();
        check("bp nothing latched", 32'(in_ready), 32'd1);

        // Reset during RUN: accept at edge 0, reset sampled at edge 2.
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrun in_ready", 32'(in_ready), 32'd1);
        check("midrun sum", 32'(sum), 32'h0);
        saw_valid = out_valid;
        for (int i = 0; i < 6; i++) begin
            step();
            saw_valid = saw_valid | out_valid;
        end
        check("midrun no out_valid", 32'(saw_valid), 32'd0);
        out_ready = 1'b0;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, "after reset", gs, gc, go);
        check("after reset sum", 32'(gs), 32'h2345);

        // Random operations against the integer model.
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            int hold;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            hold = int'($urandom_range(0, 2));
            if (i % 10 == 0) ra = 16'h8000;
            if (i % 10 == 1) rb = 16'hFFFF;
            model(ra, rb, rc, rs, es, ec, eo);
            run_op(ra, rb, rc, rs, hold, "rand", gs, gc, go);
            check("rand sum", 32'(gs), 32'(es));
            check("rand cout", 32'(gc), 32'(ec));
            check("rand overflow", 32'(go), 32'(eo));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
